// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream frame checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_chk_pkg;

  // Frame-measurement FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    OVERRUN  = 2'd2
  } chk_state_t;

  localparam int                     FRAME_CNT_W   = 16;
  localparam logic [FRAME_CNT_W-1:0] FRAME_CNT_MAX = 16'hFFFF;

  // Completed-frame counter increment that sticks at all-ones.
  function automatic logic [FRAME_CNT_W-1:0] frame_cnt_inc(input logic [FRAME_CNT_W-1:0] c);
    return (c == FRAME_CNT_MAX) ? c : c + FRAME_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// 2-entry registered skid buffer carrying data + last; ready to upstream is a flop.
// Latency: beat accepted at edge N on an empty buffer is on m_* in cycle N+1.
// Backpressure: holds at most 2 beats; s_ready drops the cycle after the skid entry fills.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   s_data/s_valid/s_ready/s_last - upstream beat and handshake
//   m_data/m_valid/m_ready/m_last - downstream beat and handshake
module axis_skid_buffer #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  logic                  rdy_en;      // lets s_ready rise only on the 2nd edge after reset
  logic [data_width-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_valid;
  logic                  skid_valid_nxt;
  logic                  accept;
  logic                  main_free;

  assign accept    = s_valid && s_ready;
  // Main register can take a new beat when empty or draining this edge.
  assign main_free = !m_valid || m_ready;

  // s_ready is only high while the skid entry is empty, so an accept never
  // coincides with a full skid entry.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (main_free) begin
      skid_valid_nxt = 1'b0;
    end else if (accept) begin
      skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      s_ready    <= rdy_en && !skid_valid_nxt;
      skid_valid <= skid_valid_nxt;
      if (main_free) begin
        // Skid entry is older than any incoming beat, so it drains first.
        if (skid_valid) begin
          m_valid <= 1'b1;
          m_data  <= skid_data;
          m_last  <= skid_last;
        end else if (accept) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_last  <= s_last;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= s_data;
        skid_last <= s_last;
      end
    end
  end

endmodule

// File: rtl/axis_frame_checker.sv
// Forwards an AXI-Stream through a skid buffer and measures each s_last-delimited frame.
// Latency: data 1 cycle through the buffer; stats/frame_done 1 cycle after the last beat's accept edge.
// Backpressure: m_ready low stalls after 2 buffered beats; s_ready is registered.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   s_data/s_valid/s_ready/s_last - upstream stream (from the FIFO master side)
//   m_data/m_valid/m_ready/m_last - forwarded stream
//   expected_len                  - expected beats per frame, 0 disables the compare
//   frame_len/frame_sum           - length and checksum of the last completed frame
//   frame_done/len_err            - completion pulse and its error qualifier
//   frame_cnt                     - completed frames, saturating
// Build option: define FRAME_CHECKSUM_EN to build the additive checksum;
// otherwise frame_sum is tied to 0.
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int data_width = 32,
  parameter int Max_len    = 4096,
  parameter int Len_width  = $clog2(Max_len) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_width-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [data_width-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  input  logic [Len_width-1:0]   expected_len,
  output logic [Len_width-1:0]   frame_len,
  output logic [data_width-1:0]  frame_sum,
  output logic                   frame_done,
  output logic                   len_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [Len_width-1:0] LEN_ONE = Len_width'(1);
  localparam logic [Len_width-1:0] LEN_MAX = Len_width'(Max_len);

  chk_state_t            state, state_nxt;
  logic [Len_width-1:0]  cnt, cnt_nxt;
  logic [Len_width-1:0]  beat_cnt;     // frame length including the current beat
  logic                  complete;     // current accepted beat closes a frame
  logic                  overrun_beat; // frame already exceeded Max_len
  logic                  len_mismatch;
  logic                  accept;

  // Completion is staged one edge so the stats land at N+1 after the last-beat accept.
  logic                  pend_vld;
  logic [Len_width-1:0]  pend_len;
  logic                  pend_err;

  axis_skid_buffer #(
    .data_width (data_width)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  assign accept = s_valid && s_ready;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    beat_cnt     = cnt;
    complete     = 1'b0;
    overrun_beat = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          beat_cnt = LEN_ONE;
          cnt_nxt  = LEN_ONE;
          // A 1-beat frame completes without leaving IDLE.
          if (s_last) begin
            complete = 1'b1;
          end else begin
            state_nxt = IN_FRAME;
          end
        end
        IN_FRAME: begin
          beat_cnt = cnt + LEN_ONE;
          cnt_nxt  = beat_cnt;
          if (s_last) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else if (beat_cnt == LEN_MAX) begin
            state_nxt = OVERRUN;
          end
        end
        OVERRUN: begin
          // Count stays pinned at Max_len while beats keep flowing.
          beat_cnt     = LEN_MAX;
          overrun_beat = 1'b1;
          if (s_last) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign len_mismatch = (expected_len != '0) && (beat_cnt != expected_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_vld   <= 1'b0;
      pend_len   <= '0;
      pend_err   <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      len_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_vld <= complete;
      if (complete) begin
        pend_len <= beat_cnt;
        pend_err <= overrun_beat || len_mismatch;
      end
      frame_done <= pend_vld;
      if (pend_vld) begin
        frame_len <= pend_len;
        len_err   <= pend_err;
        frame_cnt <= frame_cnt_inc(frame_cnt);
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [data_width-1:0] acc;
  logic [data_width-1:0] beat_sum;
  logic [data_width-1:0] pend_sum;
  logic [data_width-1:0] sum_q;

  // The first beat of a frame (accepted in IDLE) restarts the sum; carries wrap.
  assign beat_sum = (state == IDLE) ? s_data : acc + s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      pend_sum <= '0;
      sum_q    <= '0;
    end else begin
      if (accept) begin
        acc <= beat_sum;
      end
      if (complete) begin
        pend_sum <= beat_sum;
      end
      if (pend_vld) begin
        sum_q <= pend_sum;
      end
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: queue-based reference model
// compared every cycle, plus literal expectations for the directed frames.
module tb_axis_frame_checker;

  localparam int DW   = 32;
  localparam int MAXL = 4096;
  localparam int LW   = $clog2(MAXL) + 1;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [LW-1:0] expected_len;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] frame_sum;
  logic          frame_done;
  logic          len_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  axis_frame_checker #(
    .data_width (DW),
    .Max_len    (MAXL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .expected_len (expected_len),
    .frame_len    (frame_len),
    .frame_sum    (frame_sum),
    .frame_done   (frame_done),
    .len_err      (len_err),
    .frame_cnt    (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;   // m_ready: 0 always high, 1 random, 2 held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v);
    return CSUM ? v : 32'h0;
  endfunction

  // ---------------- reference model state ----------------
  logic [31:0] q_dat[$];
  logic        q_last[$];
  int          warm    = 0;
  int          cur_n   = 0;
  logic [31:0] cur_sum = 0;
  logic        st_v    = 0;
  logic [31:0] st_len  = 0;
  logic [31:0] st_sum  = 0;
  logic        st_err  = 0;
  logic        d_done  = 0;
  logic        d_err   = 0;
  logic [31:0] d_len   = 0;
  logic [31:0] d_sum   = 0;
  logic [31:0] d_cnt   = 0;
  int          n_out   = 0;
  logic [31:0] lg_len[$];
  logic [31:0] lg_sum[$];
  logic [31:0] lg_cnt[$];
  logic        lg_err[$];

  // Single compare process: checks the current cycle, then advances the model
  // by what the coming edge will do.
  always @(negedge clk) begin
    logic er, acc, fire;
    er = (warm >= 2) && (q_dat.size() < 2);
    chk("s_ready", s_ready, er);
    chk("m_valid", m_valid, q_dat.size() > 0);
    if (q_dat.size() > 0) begin
      chk("m_data", m_data, q_dat[0]);
      chk("m_last", m_last, q_last[0]);
    end
    chk("frame_done", frame_done, d_done);
    chk("frame_len", frame_len, d_len);
    chk("frame_sum", frame_sum, d_sum);
    chk("frame_cnt", frame_cnt, d_cnt);
    if (d_done) chk("len_err", len_err, d_err);
    if (frame_done) begin
      lg_len.push_back(frame_len);
      lg_sum.push_back(frame_sum);
      lg_cnt.push_back(frame_cnt);
      lg_err.push_back(len_err);
    end
    if (m_valid && m_ready) n_out++;

    if (rst) begin
      q_dat.delete(); q_last.delete();
      warm = 0; cur_n = 0; cur_sum = 0;
      st_v = 0; d_done = 0; d_err = 0;
      d_len = 0; d_sum = 0; d_cnt = 0;
    end else begin
      acc  = s_valid && er;
      fire = (q_dat.size() > 0) && m_ready;
      if (warm < 2) warm++;
      d_done = st_v;
      if (st_v) begin
        d_len = st_len; d_sum = st_sum; d_err = st_err;
        if (d_cnt != 32'hFFFF) d_cnt++;
      end
      st_v = 0;
      if (fire) begin
        void'(q_dat.pop_front());
        void'(q_last.pop_front());
      end
      if (acc) begin
        q_dat.push_back(s_data);
        q_last.push_back(s_last);
        cur_n++;
        cur_sum += s_data;
        if (s_last) begin
          st_v   = 1;
          st_len = (cur_n > MAXL) ? MAXL : cur_n;
          st_err = (cur_n > MAXL) || ((expected_len != 0) && (st_len != expected_len));
          st_sum = sx(cur_sum);
          cur_n  = 0;
          cur_sum = 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int   t;
    logic a;
    s_valid = 1'b1; s_data = d; s_last = l; t = 0;
    forever begin
      @(negedge clk); a = s_ready;
      @(posedge clk); #1;
      if (a) break;
      t++;
      if (t > 2000) begin
        n_cmp++; n_err++;
        $display("FAIL send_beat: no s_ready within 2000 cycles (t=%0t)", $time);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // kind 0: data i+1, kind 1: random, kind 2: data i
  task automatic send_frame(input int n, input int kind, input bit gaps);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = (kind == 0) ? 32'(i + 1) : (kind == 1) ? $urandom : 32'(i);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_beat(d, i == n - 1);
    end
  endtask

  task automatic settle();
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_s_ready"}, s_ready, 0);
    chk({p, "_m_valid"}, m_valid, 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_m_last"}, m_last, 0);
    chk({p, "_frame_len"}, frame_len, 0);
    chk({p, "_frame_sum"}, frame_sum, 0);
    chk({p, "_frame_done"}, frame_done, 0);
    chk({p, "_len_err"}, len_err, 0);
    chk({p, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Checks one logged completion against literal values.
  task automatic chk_log(input string p, input int idx, input logic [31:0] len,
                         input logic [31:0] sum, input logic err, input logic [31:0] cnt);
    if (idx >= lg_len.size()) begin
      n_cmp++; n_err++;
      $display("FAIL %s: completion %0d missing, only %0d logged", p, idx, lg_len.size());
    end else begin
      chk({p, "_len"}, lg_len[idx], len);
      chk({p, "_sum"}, lg_sum[idx], sum);
      chk({p, "_err"}, lg_err[idx], err);
      chk({p, "_cnt"}, lg_cnt[idx], cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int base, ob, n, pick;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1; expected_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s_ready_1st_edge", s_ready, 0);
    @(posedge clk); #1;
    chk("s_ready_2nd_edge", s_ready, 1);

    // 4-beat frame, expected length matches
    base = lg_len.size(); ob = n_out; expected_len = 4;
    send_frame(4, 0, 0); settle();
    chk("t1_ndone", lg_len.size() - base, 1);
    chk("t1_nout", n_out - ob, 4);
    chk_log("t1", base, 4, sx(32'hA), 0, 1);

    // same frame, expected length 5
    base = lg_len.size(); expected_len = 5;
    send_frame(4, 0, 0); settle();
    chk_log("t2", base, 4, sx(32'hA), 1, 2);

    // overlong frame: Max_len+3 beats
    base = lg_len.size(); ob = n_out; expected_len = 0;
    send_frame(MAXL + 3, 2, 0); settle();
    chk("t3_nout", n_out - ob, MAXL + 3);
    chk_log("t3", base, MAXL, sx(32'd8398851), 1, 3);

    // frame of exactly Max_len beats is legal
    base = lg_len.size(); expected_len = MAXL;
    send_frame(MAXL, 2, 0); settle();
    chk_log("t3b", base, MAXL, sx(32'd8386560), 0, 4);

    // two back-to-back 1-beat frames
    base = lg_len.size(); expected_len = 0;
    send_beat(32'hFFFF_FFFF, 1'b1);
    send_beat(32'h0000_0001, 1'b1);
    settle();
    chk("t4_ndone", lg_len.size() - base, 2);
    chk_log("t4a", base, 1, sx(32'hFFFF_FFFF), 0, 5);
    chk_log("t4b", base + 1, 1, sx(32'h1), 0, 6);

    // m_ready held low for 5 edges during a 6-beat frame
    base = lg_len.size(); ob = n_out; expected_len = 6;
    mode = 2;
    fork
      send_frame(6, 0, 0);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t5_s_ready_stalled", s_ready, 0);
        chk("t5_m_valid_held", m_valid, 1);
        chk("t5_m_data_head", m_data, 1);
        mode = 0;
      end
    join
    settle();
    chk("t5_nout", n_out - ob, 6);
    chk_log("t5", base, 6, sx(32'd21), 0, 7);

    // reset after 2 of 6 beats
    base = lg_len.size(); expected_len = 0;
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst1");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_no_done", lg_len.size() - base, 0);
    expected_len = 3;
    send_frame(3, 0, 0); settle();
    chk_log("t6", base, 3, sx(32'd6), 0, 1);

    // randomized frames with random gaps and backpressure
    base = lg_len.size(); mode = 1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 24);
      pick = $urandom_range(0, 3);
      expected_len = (pick == 0) ? LW'(0) : (pick == 1) ? LW'(n) :
                     (pick == 2) ? LW'(n + 1) : LW'(n - 1);
      send_frame(n, 1, 1);
    end
    mode = 0;
    settle();
    chk("t7_ndone", lg_len.size() - base, 40);
    chk("t7_final_cnt", frame_cnt, 41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

Downstream stage of the 4096-deep AXI-Stream FIFO. Consumes the FIFO's master stream, forwards it unchanged through a registered skid buffer, and measures every frame (`s_last`-delimited). For each frame it reports the length, an optional additive checksum and a length-error flag, so packet loss or corruption across the FIFO is visible at the system level.

## Interface
- `data_width`, 32, beat width.
- `Max_len`, 4096, maximum legal frame length in beats.
- `Len_width`, `$clog2(Max_len)+1`, width of length fields.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `s_data` in `data_width`: upstream beat, from the FIFO's `m_data`.
- `s_valid` in 1: upstream valid.
- `s_ready` out 1: registered ready to upstream.
- `s_last` in 1: final beat of the frame.
- `m_data` out `data_width`: forwarded beat.
- `m_valid` out 1: forwarded valid.
- `m_ready` in 1: downstream ready.
- `m_last` out 1: forwarded last.
- `expected_len` in `Len_width`: expected frame length; 0 disables the compare.
- `frame_len` out `Len_width`: beat count of the last completed frame.
- `frame_sum` out `data_width`: checksum of the last completed frame.
- `frame_done` out 1: one-cycle pulse when the stats are updated.
- `len_err` out 1: error qualifier, valid while `frame_done` is high.
- `frame_cnt` out 16: completed frames, saturates at 0xFFFF.

## Operation
- An input beat is accepted when `s_valid && s_ready` is high at the clock edge. An output beat transfers when `m_valid && m_ready` is high at the clock edge.
- The datapath is a 2-entry skid buffer (main register plus skid register). `s_ready` is driven only from a flop and equals "skid register empty". Data, last and ordering pass through unmodified.
- The FSM counts accepted input beats and has three states:
  - IDLE: the first accepted beat goes to IN_FRAME with count 1. If that beat also has `s_last` set (a 1-beat frame), the frame completes and the FSM stays in IDLE.
  - IN_FRAME: each beat increments the count. A beat with `s_last` completes the frame and returns to IDLE. If the count reaches `Max_len` without `s_last`, the FSM goes to OVERRUN.
  - OVERRUN: the count holds at `Max_len`; beats are still forwarded. A beat with `s_last` completes the frame (overrun=1) and returns to IDLE.
- Checksum: the accumulator is the sum of `s_data` modulo 2^`data_width` (carries discarded). It restarts with the first beat of each frame.
- On completion:
  - `frame_len` takes the count, saturated at `Max_len`.
  - `frame_sum` takes the accumulator.
  - `len_err` = overrun OR (`expected_len` != 0 AND count != `expected_len`).
  - `frame_cnt` increments unless already 0xFFFF.
- Back-to-back frames: the first beat of frame N+1 can arrive in the cycle right after the last beat of frame N. That beat restarts the count at 1. Completion of frame N and the new frame's first accept may fall on consecutive edges with no lost beat.
- Reset mid-frame discards the partial frame, empties both buffer entries and returns the FSM to IDLE. No `frame_done` is produced for the discarded frame.

## Timing
- Reset values (during `rst` and on the first cycle after it):
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
  - `frame_len`=0, `frame_sum`=0, `frame_done`=0, `len_err`=0, `frame_cnt`=0.
- `s_ready` goes to 1 on the second edge after `rst` is released.
- Latency: a beat accepted at edge N with the buffer empty is presented on `m_*` in cycle N+1.
- Throughput is 1 beat per cycle while `m_ready` is held high.
- Backpressure: when `m_ready` is low, at most 2 beats are held. `s_ready` falls in the cycle after the skid register fills.
- Stats registers and `frame_done` update at edge N+1 after the `s_last` beat is accepted at edge N. The stats hold until the next completion.
- `expected_len` is sampled at the edge that accepts the last beat.

## Configuration
- `FRAME_CHECKSUM_EN` defined: the accumulator is built and `frame_sum` reports the checksum.
- `FRAME_CHECKSUM_EN` undefined: the accumulator is not built and `frame_sum` is tied to 0. All other behaviour is unchanged.

## Structure
- Package `axis_chk_pkg` holds:
  - the state typedef (IDLE, IN_FRAME, OVERRUN);
  - `FRAME_CNT_W`=16;
  - `FRAME_CNT_MAX`=16'hFFFF.
- Sub-module `axis_skid_buffer` (parameter `data_width`) carries data+last and implements the registered-ready handshake. The top level holds the FSM, the counters and the stats registers.

## Test plan
- Reset, then frame of 4 beats 0x1,0x2,0x3,0x4 with `m_ready`=1 and `expected_len`=4:
  - output stream is identical, each beat 1 cycle later;
  - `frame_done` pulses once with `frame_len`=4, `frame_sum`=0xA, `len_err`=0, `frame_cnt`=1.
- Same frame with `expected_len`=5 → `len_err`=1 and `frame_len`=4.
- Frame of `Max_len`+3 beats, with `s_last` on the final beat → `frame_len`=4096, `len_err`=1, all 4099 beats forwarded.
- Two 1-beat frames on consecutive cycles (0xFFFFFFFF, then 0x1) → two `frame_done` pulses with `frame_sum`=0xFFFFFFFF, then 0x1.
- `m_ready` held low for 5 cycles during a frame:
  - `s_ready` falls after 2 beats are buffered;
  - no beat is lost or duplicated;
  - order is preserved after release.
- `rst` asserted after 2 of 6 beats:
  - all outputs return to reset values and no `frame_done` is produced;
  - a following 3-beat frame reports `frame_len`=3 and `frame_cnt`=1.
